piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in/serial-out transmitter that feeds the 4-bit serial-to-parallel receiver stage. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `sout`, with a qualifying `sout_valid` and an end-of-frame `done` pulse. Back-to-back words stream with no idle gap, so the downstream deserializer sees a continuous bit stream.

## Interface
- `WIDTH`, 4: data word width in bits; legal range is 2 to 32.
- `MSB_FIRST`, 1: 1 sends `din[WIDTH-1]` first; 0 sends `din[0]` first.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  parallel word to transmit.
- `din_valid`  in  1  `din` is offered.
- `din_ready`  out  1  transmitter can accept a word this cycle.
- `sout`  out  1  serial data bit.
- `sout_valid`  out  1  `sout` carries a frame bit this cycle.
- `done`  out  1  one-cycle pulse coincident with the last bit of a frame.
- `busy`  out  1  a frame is in progress (state SHIFT).

## Operation
- The design has one clock. Reset is synchronous and active-high.
- FSM states:
  - IDLE to SHIFT on an accept, which is a cycle with `din_valid && din_ready` at a rising edge.
  - SHIFT to IDLE after the last frame bit when no new accept occurs in that cycle.
  - SHIFT to SHIFT, reloaded, when an accept occurs on the last-bit cycle.
- On accept, `din` is captured into a WIDTH-bit shift register, and a bit counter is loaded with FRAME-1.
  - FRAME = WIDTH, or WIDTH+1 when parity is enabled.
  - The counter width is clog2(WIDTH+1).
- In SHIFT:
  - `sout` is the register's outgoing end: bit WIDTH-1 if MSB_FIRST, otherwise bit 0.
  - Each cycle the register shifts toward that end, zero-filling the other end.
  - The counter decrements by 1 each cycle. The last bit is when the counter equals 0.
- Output rules:
  - `din_ready = !rst && (state==IDLE || (state==SHIFT && count==0))`.
  - `busy = (state==SHIFT)`.
  - `sout_valid = busy`.
  - `done = busy && count==0`.
- `din` is sampled only on an accept. Changes to `din` mid-frame do not affect the frame.
- If `din_valid` is low in IDLE, the block stays in IDLE and `sout` is held at 0.
- Reset mid-frame:
  - The frame is abandoned. State goes to IDLE at that edge, and the shift register and counter clear to 0.
  - No `done` pulse is generated.
  - A `din_valid` asserted while `rst` is high is ignored, because `din_ready` is 0.

## Timing
- Reset values: `din_ready`=0 while `rst` is high and 1 in the first cycle after release. `sout`=0, `sout_valid`=0, `done`=0, `busy`=0.
- Latency: the first frame bit appears on `sout` in the cycle immediately after the accepting edge.
- Each frame occupies exactly FRAME consecutive cycles of `sout_valid`=1.
- Throughput is one bit per clock, sustained across frames.
- When a new word is accepted on the last-bit cycle, the first bit of the new frame follows on the next cycle with no gap. In that case `done` and `din_ready` are both high in that cycle.
- All outputs except `din_ready` are driven directly from flops or from a compare on state bits; they are glitch-free relative to `clk`.

## Configuration
- `PISO_TX_PARITY_EN` defined:
  - One even-parity bit, the XOR of all WIDTH captured data bits, is appended after the data bits.
  - FRAME = WIDTH+1, and `done` is asserted on the parity bit.
  - Parity is computed at accept time and stored in a 1-bit register.
- Macro not defined:
  - No parity logic or register exists, and FRAME = WIDTH.

## Test plan
- Single frame: WIDTH=4, MSB_FIRST=1, accept `din`=4'b1011 at edge 0.
  - Required: `sout`=1,0,1,1 on cycles 1–4 with `sout_valid`=1, `done` on cycle 4, `din_ready`=0 on cycles 1–3, and IDLE with `sout_valid`=0 on cycle 5.
- LSB-first: MSB_FIRST=0, `din`=4'b1011.
  - Required: `sout`=1,1,0,1 on cycles 1–4.
- Back-to-back: hold `din_valid`=1 with 4'b1011, then 4'b0110 accepted on cycle 4.
  - Required: eight consecutive valid bits 1,0,1,1,0,1,1,0, `done` on cycles 4 and 8, and no idle cycle between frames.
- Reset mid-frame: accept 4'b1111, then assert `rst` on cycle 2.
  - Required: cycle 3 has `sout_valid`=0, `sout`=0, and `done` is never asserted. `din_ready`=0 during `rst` and 1 the cycle after release. A `din_valid` held during `rst` produces no frame.
- Idle hold: `din_valid`=0 for 10 cycles after reset.
  - Required: `sout_valid`=0, `sout`=0, `busy`=0, `din_ready`=1 throughout.
- Parity (with `PISO_TX_PARITY_EN`): `din`=4'b1011.
  - Required: `sout`=1,0,1,1,1 on cycles 1–5, `done` on cycle 5.
  - With `din`=4'b0110, the fifth bit is 0.

Source files
------------

// File: rtl/piso_tx_if.sv
// piso_tx_if: parallel word handshake plus serial output bundle for piso_tx.
interface piso_tx_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, done, busy
  );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: WIDTH-bit parallel-in/serial-out transmitter, one bit per clock, gapless streaming.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    count, count_n;
  logic             last;
  logic             accept;
  logic             data_bit;
`ifdef PISO_TX_PARITY_EN
  logic             par, par_n;
`endif

  assign last          = (count == '0);
  assign bus.din_ready = !rst && ((state == IDLE) || ((state == SHIFT) && last));
  assign accept        = bus.din_valid && bus.din_ready;
  assign data_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  assign bus.busy       = (state == SHIFT);
  assign bus.sout_valid = (state == SHIFT);
  assign bus.done       = (state == SHIFT) && last;
`ifdef PISO_TX_PARITY_EN
  // Parity bit goes out on the final count, after all data bits have left the register.
  assign bus.sout = (state == SHIFT) && (last ? par : data_bit);
`else
  assign bus.sout = (state == SHIFT) && data_bit;
`endif

  // Next-state: load on accept (also on the last-bit cycle for gapless reload), else shift.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    count_n = count;
`ifdef PISO_TX_PARITY_EN
    par_n   = par;
`endif
    if (accept) begin
      state_n = SHIFT;
      shreg_n = bus.din;
      count_n = CW'(FRAME - 1);
`ifdef PISO_TX_PARITY_EN
      par_n   = ^bus.din;
`endif
    end else if (state == SHIFT) begin
      if (MSB_FIRST) shreg_n = {shreg[WIDTH-2:0], 1'b0};
      else           shreg_n = {1'b0, shreg[WIDTH-1:1]};
      if (last) state_n = IDLE;
      else      count_n = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
`ifdef PISO_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      count <= count_n;
`ifdef PISO_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench driving an MSB-first and an LSB-first piso_tx with shared stimulus.
module tb_piso_tx;
  localparam int unsigned WIDTH = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             mon_en = 1'b0;
  int               vecs = 0;
  int               errs = 0;
  logic [1:0]       qm[$];
  logic [1:0]       ql[$];
  logic [1:0]       em, el;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(WIDTH)) bm ();
  piso_tx_if #(.WIDTH(WIDTH)) bl ();

  assign bm.din       = din;
  assign bm.din_valid = din_valid;
  assign bl.din       = din;
  assign bl.din_valid = din_valid;

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm));
  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {bit, done} per frame cycle, for both bit orders.
  function automatic void push_frame(input logic [WIDTH-1:0] d);
    for (int i = 0; i < WIDTH; i++) begin
      qm.push_back({d[WIDTH-1-i], (FRAME == WIDTH) && (i == WIDTH - 1)});
      ql.push_back({d[i],         (FRAME == WIDTH) && (i == WIDTH - 1)});
    end
`ifdef PISO_TX_PARITY_EN
    qm.push_back({^d, 1'b1});
    ql.push_back({^d, 1'b1});
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitors: pop on every valid bit; idle cycles must not owe bits or pulse done.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bm.sout_valid === 1'b1) begin
        if (qm.size() == 0) chk("msb_unexpected_bit", 32'd1, 32'd0);
        else begin
          em = qm.pop_front();
          chk("msb_sout", 32'(bm.sout), 32'(em[1]));
          chk("msb_done", 32'(bm.done), 32'(em[0]));
        end
      end else begin
        chk("msb_idle_done", 32'(bm.done), 32'd0);
        if (qm.size() != 0) chk("msb_gap", 32'(bm.sout_valid), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bl.sout_valid === 1'b1) begin
        if (ql.size() == 0) chk("lsb_unexpected_bit", 32'd1, 32'd0);
        else begin
          el = ql.pop_front();
          chk("lsb_sout", 32'(bl.sout), 32'(el[1]));
          chk("lsb_done", 32'(bl.done), 32'(el[0]));
        end
      end else begin
        chk("lsb_idle_done", 32'(bl.done), 32'd0);
        if (ql.size() != 0) chk("lsb_gap", 32'(bl.sout_valid), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0;
    repeat (3) step();
    chk("rst_ready", 32'(bm.din_ready), 32'd0);
    chk("rst_busy", 32'(bm.busy), 32'd0);
    chk("rst_sout_valid", 32'(bm.sout_valid), 32'd0);
    chk("rst_done", 32'(bm.done), 32'd0);
    chk("rst_sout", 32'(bm.sout), 32'd0);
    mon_en = 1'b1;

    // Idle hold after release.
    for (int c = 0; c < 10; c++) begin
      step();
      rst = 1'b0;
      #1;
      chk("idle_sout_valid", 32'(bm.sout_valid), 32'd0);
      chk("idle_sout", 32'(bm.sout), 32'd0);
      chk("idle_busy", 32'(bm.busy), 32'd0);
      chk("idle_ready", 32'(bm.din_ready), 32'd1);
      chk("idle_ready_lsb", 32'(bl.din_ready), 32'd1);
    end

    // Single frame 1011; din changes mid-frame must not matter.
    step();
    din = 4'b1011; din_valid = 1'b1; push_frame(4'b1011);
    #1 chk("single_ready0", 32'(bm.din_ready), 32'd1);
    for (int c = 1; c <= int'(FRAME) + 1; c++) begin
      step();
      din_valid = 1'b0; din = 4'b0100;
      #1;
      chk("single_ready", 32'(bm.din_ready), 32'(c >= int'(FRAME)));
      chk("single_busy", 32'(bm.busy), 32'(c <= int'(FRAME)));
    end

    // Back-to-back: 1011 held, then 0110 accepted on the last-bit cycle.
    step();
    din = 4'b1011; din_valid = 1'b1; push_frame(4'b1011);
    for (int c = 1; c <= 2 * int'(FRAME) + 1; c++) begin
      step();
      if (c < int'(FRAME)) begin
        din = 4'b1011; din_valid = 1'b1;
      end else if (c == int'(FRAME)) begin
        din = 4'b0110; din_valid = 1'b1; push_frame(4'b0110);
      end else begin
        din = 4'b0000; din_valid = 1'b0;
      end
      #1;
      chk("b2b_ready", 32'(bm.din_ready), 32'((c == int'(FRAME)) || (c >= 2 * int'(FRAME))));
      chk("b2b_busy", 32'(bm.busy), 32'(c <= 2 * int'(FRAME)));
    end

    // Reset mid-frame: 1111 accepted, rst asserted in cycle 2 with din_valid held.
    step();
    din = 4'b1111; din_valid = 1'b1; push_frame(4'b1111);
    step();
    din_valid = 1'b0;
    step();
    rst = 1'b1; din_valid = 1'b1;
    qm.delete(); ql.delete();
    #1 chk("mrst_ready", 32'(bm.din_ready), 32'd0);
    step();
    #1;
    chk("mrst_sout_valid", 32'(bm.sout_valid), 32'd0);
    chk("mrst_sout", 32'(bm.sout), 32'd0);
    chk("mrst_done", 32'(bm.done), 32'd0);
    chk("mrst_busy_lsb", 32'(bl.busy), 32'd0);
    chk("mrst_ready2", 32'(bm.din_ready), 32'd0);
    step();
    rst = 1'b0; din_valid = 1'b0;
    #1 chk("mrst_release_ready", 32'(bm.din_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      #1 chk("mrst_no_frame", 32'(bm.busy), 32'd0);
    end

    // Single frame 0110 (parity bit 0 when enabled).
    step();
    din = 4'b0110; din_valid = 1'b1; push_frame(4'b0110);
    step();
    din_valid = 1'b0;
    repeat (int'(FRAME) + 2) step();
    chk("drain_msb", 32'(qm.size()), 32'd0);
    chk("drain_lsb", 32'(ql.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
